// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the 16-bit ALU sequencer: ALU opcodes, operation and state enums.
package definitions;

    localparam int OPW_DEF = 5;

    localparam logic [OPW_DEF-1:0] kMOV = 5'd0;
    localparam logic [OPW_DEF-1:0] kADD = 5'd1;
    localparam logic [OPW_DEF-1:0] kXOR = 5'd2;
    localparam logic [OPW_DEF-1:0] kLSH = 5'd3;
    localparam logic [OPW_DEF-1:0] kRSH = 5'd4;

    typedef enum logic [1:0] {ADD16, XOR16, SHL16, SHR16} seq_op_t;
    typedef enum logic [1:0] {IDLE, FIRST, SECOND, FIN} seq_state_t;

    function automatic logic [OPW_DEF-1:0] op_code(input seq_op_t op);
        case (op)
            ADD16:   return kADD;
            XOR16:   return kXOR;
            SHL16:   return kLSH;
            default: return kRSH;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Runs 16-bit ADD/XOR/SHL/SHR on an external 8-bit combinational ALU as LSW/MSW pass pairs.
// ALU_SEQ_ZERO_FLAG_EN adds a ZERO16 flag register; without it ZERO16 is tied low.
module alu_seq_ctrl
    import definitions::*;
#(
    parameter int DW  = 8,
    parameter int OPW = 5,
    parameter int SHW = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [1:0]        opsel_i,
    input  logic [SHW-1:0]    shamt_i,
    input  logic [2*DW-1:0]   opa_i,
    input  logic [2*DW-1:0]   opb_i,
    output logic [2*DW-1:0]   result_o,
    output logic              carry_o,
    output logic              zero16_o,
    output logic              done_o,
    output logic [DW-1:0]     alu_a_o,
    output logic [DW-1:0]     alu_b_o,
    output logic [OPW-1:0]    alu_op_o,
    output logic              alu_sc_in_o,
    input  logic [DW-1:0]     alu_out_i,
    input  logic              alu_sc_out_i,
    input  logic              alu_zero_i
);

    seq_state_t        state_q, state_d;
    seq_op_t           op_q, op_d;
    logic [2*DW-1:0]   res_q, res_d;
    logic [2*DW-1:0]   opb_q, opb_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              cy_q, cy_d;
    logic              carry_q, carry_d;
    logic              is_shift_q;
    logic              hi_half;

    assign is_shift_q = (op_q == SHL16) || (op_q == SHR16);
    // SHR walks MSW first so the bit leaving the upper half lands in the lower half.
    assign hi_half    = (state_q == FIRST) ? (op_q == SHR16) : (op_q != SHR16);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        res_d       = res_q;
        opb_d       = opb_q;
        cnt_d       = cnt_q;
        cy_d        = cy_q;
        carry_d     = carry_q;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_op_o    = OPW'(kMOV);
        alu_sc_in_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d    = seq_op_t'(opsel_i);
                    res_d   = opa_i;
                    opb_d   = opb_i;
                    cnt_d   = shamt_i;
                    cy_d    = 1'b0;
                    carry_d = 1'b0;
                    if ((seq_op_t'(opsel_i) == SHL16 || seq_op_t'(opsel_i) == SHR16)
                        && shamt_i == '0)
                        state_d = FIN;
                    else
                        state_d = FIRST;
                end
            end
            FIRST, SECOND: begin
                alu_a_o  = hi_half ? res_q[2*DW-1:DW] : res_q[DW-1:0];
                if (!is_shift_q)
                    alu_b_o = hi_half ? opb_q[2*DW-1:DW] : opb_q[DW-1:0];
                alu_op_o = OPW'(op_code(op_q));
                if (hi_half)
                    res_d[2*DW-1:DW] = alu_out_i;
                else
                    res_d[DW-1:0] = alu_out_i;
                if (state_q == FIRST) begin
                    cy_d    = alu_sc_out_i;
                    state_d = SECOND;
                end else begin
                    alu_sc_in_o = cy_q;
                    carry_d     = (op_q == XOR16) ? 1'b0 : alu_sc_out_i;
                    if (is_shift_q && cnt_q > SHW'(1)) begin
                        cnt_d   = cnt_q - SHW'(1);
                        state_d = FIRST;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= ADD16;
            res_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zf_q, zf_d;

    // The last iteration's two passes overwrite whatever earlier iterations left.
    always_comb begin
        zf_d = zf_q;
        case (state_q)
            IDLE:    if (start_i) zf_d = (opa_i == '0);
            FIRST:   zf_d = alu_zero_i;
            SECOND:  zf_d = zf_q & alu_zero_i;
            default: zf_d = zf_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) zf_q <= 1'b0;
        else       zf_q <= zf_d;
    end

    assign zero16_o = zf_q;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero_i;
    assign zero16_o        = 1'b0;
`endif

    assign ready_o  = (state_q == IDLE);
    assign done_o   = (state_q == FIN);
    assign result_o = res_q;
    assign carry_o  = carry_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 8-bit ALU beside the DUT, 16-bit reference model, vector table and random ops.
module tb_alu_seq_ctrl;
    import definitions::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [1:0]  opsel;
    logic [3:0]  shamt;
    logic [15:0] opa, opb;
    logic [15:0] result;
    logic        carry, zero16, done;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [4:0]  alu_op;
    logic        alu_sc_in, alu_sc_out, alu_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;
    logic sc_out1, sc_in2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready),
        .opsel_i(opsel), .shamt_i(shamt), .opa_i(opa), .opb_i(opb),
        .result_o(result), .carry_o(carry), .zero16_o(zero16), .done_o(done),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_sc_in_o(alu_sc_in),
        .alu_out_i(alu_out), .alu_sc_out_i(alu_sc_out), .alu_zero_i(alu_zero)
    );

    always_comb begin
        alu_out    = alu_a;
        alu_sc_out = 1'b0;
        case (alu_op)
            kADD: {alu_sc_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_in};
            kXOR: alu_out = alu_a ^ alu_b;
            kLSH: begin alu_out = {alu_a[6:0], alu_sc_in}; alu_sc_out = alu_a[7]; end
            kRSH: begin alu_out = {alu_sc_in, alu_a[7:1]}; alu_sc_out = alu_a[0]; end
            default: alu_out = alu_a;
        endcase
    end
    assign alu_zero = (alu_out == 8'd0);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh, output logic [15:0] r, output logic c,
                         output int lat);
        logic [16:0] s;
        r = a; c = 1'b0; lat = 3;
        case (op)
            2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            2'd1: r = a ^ b;
            2'd2: begin for (int i = 0; i < int'(sh); i++) begin c = r[15]; r = r << 1; end
                        lat = 1 + 2 * int'(sh); end
            default: begin for (int i = 0; i < int'(sh); i++) begin c = r[0]; r = r >> 1; end
                           lat = 1 + 2 * int'(sh); end
        endcase
    endtask

    function automatic logic exp_zero(input logic [15:0] r);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        return r == 16'd0;
`else
        return (r == 16'd0) & 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh, output logic [15:0] r, output logic c,
                          output logic z, output int lat);
        int guard = 0;
        while (!ready && guard < 100) begin @(negedge clk); guard++; end
        if (!ready) check("ready_wait", 32'd0, 32'd1);
        opsel = op; opa = a; opb = b; shamt = sh; start = 1'b1;
        acc_cyc = cyc;
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) sc_out1 = alu_sc_out;
            if (k == 2) sc_in2 = alu_sc_in;
            if (done) begin lat = k; break; end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
        r = result; c = carry; z = zero16;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b;
        logic [3:0]  sh;
        logic [15:0] er;
        logic        ec;
        int          elat;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [15:0] r, er, a, b;
        logic c, z, ec;
        logic [1:0] op;
        logic [3:0] sh;
        int lat, elat, acc1, ndone, k, dk;

        vt[0] = '{2'd0, 16'h00FF, 16'h0001, 4'd0, 16'h0100, 1'b0, 3};
        vt[1] = '{2'd0, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b1, 3};
        vt[2] = '{2'd2, 16'h8001, 16'h0000, 4'd1, 16'h0002, 1'b1, 3};
        vt[3] = '{2'd2, 16'h00F0, 16'h0000, 4'd3, 16'h0780, 1'b0, 7};
        vt[4] = '{2'd3, 16'h0181, 16'h0000, 4'd4, 16'h0018, 1'b0, 9};
        vt[5] = '{2'd3, 16'h0181, 16'h0000, 4'd0, 16'h0181, 1'b0, 1};
        vt[6] = '{2'd1, 16'hA5A5, 16'hA5A5, 4'd7, 16'h0000, 1'b0, 3};
        vt[7] = '{2'd3, 16'h8000, 16'h0000, 4'd15, 16'h0001, 1'b0, 31};
        vt[8] = '{2'd0, 16'h1234, 16'hEDCC, 4'd0, 16'h0000, 1'b1, 3};

        rst = 1'b1; start = 1'b0; opsel = 2'd0; shamt = 4'd0; opa = 16'd0; opb = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_zero16", 32'(zero16), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'(kMOV));
        check("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, r, c, z, lat);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vt[i].er));
            check($sformatf("vec%0d_carry", i), 32'(c), 32'(vt[i].ec));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].elat));
            check($sformatf("vec%0d_zero16", i), 32'(z), 32'(exp_zero(vt[i].er)));
            if (i == 0) begin
                check("add_lsw_sc_out", 32'(sc_out1), 32'd1);
                check("add_msw_sc_in", 32'(sc_in2), 32'd1);
            end
        end

        // START pulsed during SECOND must not disturb the running op or queue another
        @(negedge clk);
        opsel = 2'd0; opa = 16'h1111; opb = 16'h2222; shamt = 4'd0; start = 1'b1;
        dk = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin start = 1'b1; opsel = 2'd1; opa = 16'hFFFF; end
            if (k == 3) start = 1'b0;
            if (done && dk == 0) begin
                dk = k;
                check("ign_result", 32'(result), 32'h3333);
            end
        end
        check("ign_done_cycle", 32'(dk), 32'd3);
        check("ign_idle_after", 32'(ready), 32'd1);
        check("ign_result_held", 32'(result), 32'h3333);

        // Back-to-back XOR16: next accept lands in the cycle after FIN
        run_op(2'd1, 16'h0F0F, 16'h00FF, 4'd0, r, c, z, lat);
        acc1 = acc_cyc;
        check("fin_not_ready", 32'(ready), 32'd0);
        run_op(2'd1, 16'h1234, 16'h1234, 4'd0, r, c, z, lat);
        check("b2b_spacing", 32'(acc_cyc - acc1), 32'd4);
        check("b2b_result", 32'(r), 32'h0000);
        check("b2b_zero16", 32'(z), 32'(exp_zero(16'h0000)));

        // Asynchronous reset in the middle of a long shift
        @(negedge clk);
        opsel = 2'd2; opa = 16'h1234; shamt = 4'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_carry", 32'(carry), 32'd0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        check("arst_idle", 32'(ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? (16'd0 - a) : 16'($urandom);
            sh = 4'($urandom_range(0, 15));
            model(op, a, b, sh, er, ec, elat);
            run_op(op, a, b, sh, r, c, z, lat);
            check($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
            check($sformatf("rnd%0d_carry", i), 32'(c), 32'(ec));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_zero16", i), 32'(z), 32'(exp_zero(er)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that runs 16-bit operations on the 8-bit combinational ALU. Each operation is split into LSW/MSW passes, and carry or shift bits are chained between halves through an internal carry register. Multi-bit shifts are performed as repeated 1-bit passes. The block sits between the instruction decoder (start/done handshake) and the ALU, whose ports it drives exclusively while busy.

## Interface
- DW, 8, ALU data width (one half-word)
- OPW, 5, ALU opcode width
- SHW, 4, shift-amount width (0..15)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  request; accepted only when READY=1
- READY  out  1  high in IDLE only
- OPSEL  in  2  00 ADD16, 01 XOR16, 10 SHL16, 11 SHR16
- SHAMT  in  SHW  shift count (ignored for ADD16/XOR16)
- OPA, OPB  in  2*DW  operands
- RESULT  out  2*DW  registered result; holds until next accept
- CARRY  out  1  carry out of bit 15 (ADD16), last bit shifted out (shifts), 0 (XOR16)
- ZERO16  out  1  RESULT==0 (see Configuration)
- DONE  out  1  one-cycle pulse: RESULT/CARRY/ZERO16 valid
- ALU_A, ALU_B  out  DW  ALU data inputs
- ALU_OP  out  OPW  ALU opcode
- ALU_SC_IN  out  1  ALU shift/carry in
- ALU_OUT  in  DW; ALU_SC_OUT  in  1; ALU_ZERO  in  1  ALU results

## Operation
- States: IDLE, FIRST, SECOND, FIN.
- IDLE: READY=1. On START, latch OPA→RES, OPB→OPB_r, SHAMT→CNT, clear CY.
  - Next state: FIN if a shift has SHAMT=0; otherwise FIRST.
- Pass order:
  - ADD16, XOR16, SHL16: FIRST=LSW, SECOND=MSW.
  - SHR16: FIRST=MSW, SECOND=LSW.
- FIRST: ALU_SC_IN=0. The ALU result is registered into the corresponding RES half, and ALU_SC_OUT is registered into CY.
- SECOND: ALU_SC_IN=CY. The ALU result is registered into the other RES half, and ALU_SC_OUT is registered into CARRY.
- ALU driving per operation:
  - ADD16: ALU_OP=kADD, ALU_A=RES half, ALU_B=OPB_r half.
  - XOR16: ALU_OP=kXOR, same operands; CARRY forced 0.
  - SHL16: ALU_OP=kLSH, ALU_B=0.
  - SHR16: ALU_OP=kRSH, ALU_B=0.
- After SECOND:
  - Shift with CNT>1: decrement CNT, return to FIRST.
  - Otherwise: go to FIN.
- FIN: DONE=1, READY=0; next state IDLE.
- Outside FIRST/SECOND: ALU_A=ALU_B=0, ALU_OP=kMOV, ALU_SC_IN=0.
- START outside IDLE is ignored; there is no queueing.
- Arithmetic is modulo 2^16. The carry chain uses only CY; nothing wraps into other bits.

## Timing
- Reset values:
  - State IDLE; READY=1.
  - DONE=0, RESULT=0, CARRY=0, ZERO16=0, CNT=0, CY=0.
  - ALU outputs 0, except ALU_OP=kMOV.
- Define the accept edge as t0. DONE is high in cycle t0+1+2N:
  - N=1 for ADD16/XOR16.
  - N=SHAMT for shifts.
  - So ADD16 completes at t0+3, and SHAMT=0 completes at t0+1 with RESULT=OPA, CARRY=0.
- Earliest next accept is the cycle after FIN, i.e. back-to-back throughput of 2N+2 cycles.
- RESET mid-operation: abort immediately, all registers return to reset values, no DONE is issued.
- ALU is combinational. Each pass uses one cycle, with results captured at the end of that cycle.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined:
  - A ZF register ANDs ALU_ZERO across both passes of the final iteration.
  - ZERO16 is valid with DONE and held until the next accept.
- ALU_SEQ_ZERO_FLAG_EN undefined: ZERO16 is tied to 0, and no ZF register exists.

## Structure
- Shared package `definitions` holds:
  - The ALU opcode constants kADD, kXOR, kLSH, kRSH, kMOV.
  - typedef enum seq_op_t {ADD16, XOR16, SHL16, SHR16}.
  - typedef enum seq_state_t {IDLE, FIRST, SECOND, FIN}.
- No sub-module. The ALU is instantiated by the parent beside this block and wired to the ALU_* ports.

## Test plan
- ADD16 0x00FF+0x0001 -> RESULT 0x0100, CARRY 0. LSW pass shows ALU_SC_OUT=1 and MSW pass shows ALU_SC_IN=1. DONE at t0+3.
- ADD16 0xFFFF+0x0001 -> RESULT 0x0000, CARRY 1. ZERO16=1 with ALU_SEQ_ZERO_FLAG_EN; ZERO16=0 without it.
- SHL16 0x8001 SHAMT=1 -> 0x0002, CARRY 1. SHL16 0x00F0 SHAMT=3 -> 0x0780, CARRY 0, DONE at t0+7.
- SHR16 0x0181 SHAMT=4 -> 0x0018, CARRY 0. SHAMT=0 -> RESULT 0x0181, CARRY 0, DONE at t0+1.
- START pulsed while in SECOND -> ignored, first result unchanged. RESET asserted mid-SHL16 -> READY=1, DONE=0, RESULT=0 immediately (asynchronous).
- XOR16 0xA5A5^0xA5A5 -> RESULT 0x0000, CARRY 0, ZERO16 1 (macro on). Back-to-back XOR16 accepted in the cycle after FIN.
